// File: rtl/lfsr_stream_pkg.sv
// Shared constants and the single-step Fibonacci LFSR function used by the
// unrolled keystream generator.
package lfsr_stream_pkg;

  localparam int unsigned LFSR_MAX_W = 32;

  localparam logic [7:0] DEFAULT_POLY_8 = 8'h8E;
  localparam logic [7:0] DEFAULT_SEED_8 = 8'hA5;

  typedef struct packed {
    logic [LFSR_MAX_W-1:0] next_state;
    logic                  ks_bit;
  } lfsr_step_t;

  // state/poly must be zero-extended above bit n-1; n is the real LFSR width.
  function automatic lfsr_step_t lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] poly,
    input int unsigned           n
  );
    lfsr_step_t r;
    logic       fb;
    fb           = ^(state & poly);
    r.next_state = (state >> 1) | ({{(LFSR_MAX_W-1){1'b0}}, fb} << (n - 1));
    r.ks_bit     = r.next_state[0];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_stream_xor_unroll.sv
// Combinational DW-step unrolled LFSR: produces the keystream word, the
// state after DW steps, and the data word XORed with the keystream.
module lfsr_unroll
  import lfsr_stream_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8
) (
  input  logic [N-1:0]  state,
  input  logic [N-1:0]  poly,
  input  logic [DW-1:0] data,
  output logic [N-1:0]  next_state,
  output logic [DW-1:0] ks,
  output logic [DW-1:0] data_xor
);

  logic [LFSR_MAX_W-1:0] s;
  logic [LFSR_MAX_W-1:0] p;
  lfsr_step_t            r;

  always_comb begin
    s          = '0;
    p          = '0;
    r          = '0;
    ks         = '0;
    s[N-1:0]   = state;
    p[N-1:0]   = poly;
    for (int unsigned k = 0; k < DW; k++) begin
      r     = lfsr_step(s, p, N);
      s     = r.next_state;
      ks[k] = r.ks_bit;
    end
    next_state = s[N-1:0];
  end

  assign data_xor = data ^ ks;

endmodule

// File: rtl/lfsr_stream_xor.sv
// Stream XOR cipher: DW keystream bits per accepted word from an N-bit
// Fibonacci LFSR, runtime-loadable seed/poly, one registered output stage.
module lfsr_stream_xor
  import lfsr_stream_pkg::*;
#(
  parameter int unsigned    N            = 8,
  parameter int unsigned    DW           = 8,
  parameter logic [N-1:0]   DEFAULT_POLY = DEFAULT_POLY_8,
  parameter logic [N-1:0]   DEFAULT_SEED = DEFAULT_SEED_8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_load,
  input  logic [N-1:0]  cfg_seed,
  input  logic [N-1:0]  cfg_poly,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [N-1:0]  state,
  output logic [31:0]   word_cnt
);

  logic [N-1:0]  poly_q;
  logic [N-1:0]  next_state;
  logic [DW-1:0] ks;
  logic [DW-1:0] data_xor;
  logic          accept;

  lfsr_unroll #(
    .N  (N),
    .DW (DW)
  ) u_unroll (
    .state      (state),
    .poly       (poly_q),
    .data       (in_data),
    .next_state (next_state),
    .ks         (ks),
    .data_xor   (data_xor)
  );

  // cfg_load stalls input so a load and a keystream advance never collide.
  assign in_ready = !cfg_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DEFAULT_SEED;
      poly_q    <= DEFAULT_POLY;
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      if (cfg_load) begin
        state    <= (cfg_seed == '0) ? DEFAULT_SEED : cfg_seed;
        poly_q   <= (cfg_poly == '0) ? DEFAULT_POLY : cfg_poly;
        word_cnt <= '0;
      end else if (accept) begin
        state    <= next_state;
        word_cnt <= word_cnt + 32'd1;
      end

      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= data_xor;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_stream_xor.sv
// Directed bench for lfsr_stream_xor: DW=8 instance for the stream/config
// behaviour and a DW=1 instance for the bit-serial keystream sequence.
module tb_lfsr_stream_xor;

  logic        clk;
  logic        rst;

  logic        cfg_load;
  logic [7:0]  cfg_seed;
  logic [7:0]  cfg_poly;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [7:0]  state;
  logic [31:0] word_cnt;

  logic        in_valid1;
  logic        in_ready1;
  logic [0:0]  in_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic [0:0]  out_data1;
  logic [7:0]  state1;
  logic [31:0] word_cnt1;

  int unsigned n_checks;
  int unsigned n_fail;

  lfsr_stream_xor #(
    .N  (8),
    .DW (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_seed  (cfg_seed),
    .cfg_poly  (cfg_poly),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .state     (state),
    .word_cnt  (word_cnt)
  );

  lfsr_stream_xor #(
    .N  (8),
    .DW (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (1'b0),
    .cfg_seed  (8'h00),
    .cfg_poly  (8'h00),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1),
    .state     (state1),
    .word_cnt  (word_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DW=1 from seed A5: keystream bits and state after each single step
  logic [0:0] exp_bit1 [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_st1  [8] = '{8'h52, 8'hA9, 8'h54, 8'hAA, 8'hD5, 8'h6A, 8'h35, 8'h9A};

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    cfg_load   = 1'b0;
    cfg_seed   = 8'h00;
    cfg_poly   = 8'h00;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = 1'b0;
    out_ready1 = 1'b0;

    #2;
    check_eq("rst_state", 32'(state), 32'hA5);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_data", 32'(out_data), 32'h0);
    check_eq("rst_word_cnt", word_cnt, 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // First word from the default seed/poly
    in_valid  = 1'b1;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("w1_out_data", 32'(out_data), 32'h52);
    check_eq("w1_out_valid", 32'(out_valid), 32'h1);
    check_eq("w1_state", 32'(state), 32'h9A);
    check_eq("w1_word_cnt", word_cnt, 32'h1);
    tick();
    check_eq("drain_out_valid", 32'(out_valid), 32'h0);

    // cfg_load together with in_valid: no accept
    cfg_load = 1'b1;
    cfg_seed = 8'hA5;
    cfg_poly = 8'h8E;
    in_valid = 1'b1;
    in_data  = 8'h52;
    #1;
    check_eq("cfg_blocks_in_ready", 32'(in_ready), 32'h0);
    tick();
    cfg_load = 1'b0;
    check_eq("cfg_no_accept_valid", 32'(out_valid), 32'h0);
    check_eq("cfg_state", 32'(state), 32'hA5);
    check_eq("cfg_word_cnt", word_cnt, 32'h0);

    // Symmetric decrypt of 0x52
    tick();
    in_valid = 1'b0;
    check_eq("dec_out_data", 32'(out_data), 32'h00);
    check_eq("dec_out_valid", 32'(out_valid), 32'h1);
    check_eq("dec_word_cnt", word_cnt, 32'h1);

    // Reload while a word is pending and stalled: pending word survives
    out_ready = 1'b0;
    cfg_load  = 1'b1;
    tick();
    cfg_load = 1'b0;
    check_eq("cfg_pending_valid", 32'(out_valid), 32'h1);
    check_eq("cfg_pending_data", 32'(out_data), 32'h00);
    check_eq("cfg_reload_state", 32'(state), 32'hA5);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    tick();
    in_valid = 1'b0;
    check_eq("ff_out_data", 32'(out_data), 32'hAD);
    check_eq("ff_state", 32'(state), 32'h9A);

    // Zero seed/poly substitution, starting from a non-default config
    cfg_load = 1'b1;
    cfg_seed = 8'h33;
    cfg_poly = 8'hB8;
    tick();
    check_eq("cfg_custom_seed", 32'(state), 32'h33);
    cfg_seed = 8'h00;
    cfg_poly = 8'h00;
    tick();
    cfg_load = 1'b0;
    check_eq("zero_seed_state", 32'(state), 32'hA5);
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    check_eq("zero_poly_ks", 32'(out_data), 32'h52);
    check_eq("zero_poly_state", 32'(state), 32'h9A);

    // Backpressure
    cfg_load = 1'b1;
    cfg_seed = 8'hA5;
    cfg_poly = 8'h8E;
    tick();
    cfg_load  = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_out_data", 32'(out_data), 32'h52);
      check_eq("bp_in_ready", 32'(in_ready), 32'h0);
      check_eq("bp_state", 32'(state), 32'h9A);
      check_eq("bp_word_cnt", word_cnt, 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check_eq("bp_next_ks", 32'(out_data), 32'hCD);
    check_eq("bp_next_state", 32'(state), 32'hB7);
    check_eq("bp_next_word_cnt", word_cnt, 32'h2);
    tick();
    check_eq("bp_drained", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    check_eq("pre_rst_out_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("async_rst_state", 32'(state), 32'hA5);
    check_eq("async_rst_word_cnt", word_cnt, 32'h0);
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    tick();

    // DW=1 keystream sequence from the default seed
    check_eq("dw1_rst_state", 32'(state1), 32'hA5);
    in_valid1  = 1'b1;
    in_data1   = 1'b0;
    out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("dw1_bit", 32'(out_data1), 32'(exp_bit1[i]));
      check_eq("dw1_state", 32'(state1), 32'(exp_st1[i]));
    end
    in_valid1 = 1'b0;
    check_eq("dw1_word_cnt", word_cnt1, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
